// File: rtl/usb_tx_serializer_if.sv
// rtl/usb_tx_serializer_if.sv - byte handshake between packet layer and USB TX bit engine
//
// Purpose: carries packet bytes from the packet/PID layer into the serializer.
// Signals:
//   tx_valid  packet layer -> serializer : byte available, held for the whole packet
//   tx_data   packet layer -> serializer : byte to send, LSB first
//   tx_ready  serializer -> packet layer : byte consumed on this clk edge
// Modports: master = packet layer side, slave = serializer side.

interface usb_tx_serializer_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/usb_tx_serializer.sv
// rtl/usb_tx_serializer.sv - USB full/low-speed transmit bit engine (SYNC, stuffing, NRZI, EOP)
//
// Purpose: takes packet bytes, prepends SYNC, bit-stuffs, NRZI-encodes and
// drives the D+/D- pair, then closes the packet with SE0 SE0 J.
// Ports:
//   clk, rst  system clock, synchronous active-high reset
//   clken     one-clk strobe at the bit rate; state only moves when high
//   tx        byte handshake (slave side of usb_tx_serializer_if)
//   dp, dn    registered line drive
//   oe        registered pad output enable
//   busy      registered, high from packet start through the final J bit

module usb_tx_serializer #(
  parameter bit LOW_SPEED = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clken,
  usb_tx_serializer_if.slave  tx,
  output logic                dp,
  output logic                dn,
  output logic                oe,
  output logic                busy
);

  localparam logic       J_DP = ~LOW_SPEED;
  localparam logic       J_DN = LOW_SPEED;
  localparam logic [7:0] SYNC_PATTERN = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP_SE0_1,
    ST_EOP_SE0_2,
    ST_EOP_J
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;   // bits of the current byte already on the line
  logic [2:0] ones_q, ones_d;         // consecutive ones emitted
  logic       dp_q, dp_d;
  logic       dn_q, dn_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;

  logic       do_emit;
  logic       tx_bit;
  logic       ready;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    ones_d    = ones_q;
    dp_d      = dp_q;
    dn_d      = dn_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    do_emit   = 1'b0;
    tx_bit    = 1'b0;
    ready     = 1'b0;

    if (clken) begin
      case (state_q)
        ST_IDLE: begin
          if (tx.tx_valid) begin
            // First SYNC bit goes out on the same edge that samples tx_valid.
            state_d   = ST_SYNC;
            shift_d   = {1'b0, SYNC_PATTERN[7:1]};
            bit_cnt_d = 4'd1;
            tx_bit    = SYNC_PATTERN[0];
            do_emit   = 1'b1;
            oe_d      = 1'b1;
            busy_d    = 1'b1;
          end
        end

        ST_SYNC, ST_DATA: begin
          if (ones_q == 3'd6) begin
            // Stuff bit: a forced 0, so toggle the line and restart the run.
            dp_d   = dn_q;
            dn_d   = dp_q;
            ones_d = 3'd0;
          end else if (bit_cnt_q == 4'd8) begin
            if (tx.tx_valid) begin
              ready     = 1'b1;
              state_d   = ST_DATA;
              shift_d   = {1'b0, tx.tx_data[7:1]};
              bit_cnt_d = 4'd1;
              tx_bit    = tx.tx_data[0];
              do_emit   = 1'b1;
            end else begin
              state_d = ST_EOP_SE0_1;
              dp_d    = 1'b0;
              dn_d    = 1'b0;
            end
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            tx_bit    = shift_q[0];
            do_emit   = 1'b1;
          end
        end

        ST_EOP_SE0_1: begin
          state_d = ST_EOP_SE0_2;
        end

        ST_EOP_SE0_2: begin
          state_d = ST_EOP_J;
          dp_d    = J_DP;
          dn_d    = J_DN;
        end

        ST_EOP_J: begin
          state_d   = ST_IDLE;
          oe_d      = 1'b0;
          busy_d    = 1'b0;
          shift_d   = 8'h00;
          bit_cnt_d = 4'd0;
          ones_d    = 3'd0;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // NRZI: a 0 toggles J<->K, a 1 holds the line.
      if (do_emit) begin
        if (tx_bit) begin
          ones_d = ones_q + 3'd1;
        end else begin
          dp_d   = dn_q;
          dn_d   = dp_q;
          ones_d = 3'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= 8'h00;
      bit_cnt_q <= 4'd0;
      ones_q    <= 3'd0;
      dp_q      <= J_DP;
      dn_q      <= J_DN;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      ones_q    <= ones_d;
      dp_q      <= dp_d;
      dn_q      <= dn_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
    end
  end

  assign tx.tx_ready = ready & ~rst;
  assign dp          = dp_q;
  assign dn          = dn_q;
  assign oe          = oe_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_usb_tx_serializer.sv
// tb/tb_usb_tx_serializer.sv - directed bench for usb_tx_serializer (FS and LS instances)
//
// Purpose: drives packets into a full-speed and a low-speed serializer and
// compares the line, oe, busy and tx_ready against hand-computed sequences.
// Line symbols: J, K, 0 = SE0.

module tb_usb_tx_serializer;

  logic clk = 1'b0;
  logic rst;
  logic clken;

  always #5 clk = ~clk;

  usb_tx_serializer_if if_fs();
  usb_tx_serializer_if if_ls();

  logic dp_fs, dn_fs, oe_fs, busy_fs;
  logic dp_ls, dn_ls, oe_ls, busy_ls;

  usb_tx_serializer #(.LOW_SPEED(1'b0)) dut_fs (
    .clk   (clk),
    .rst   (rst),
    .clken (clken),
    .tx    (if_fs.slave),
    .dp    (dp_fs),
    .dn    (dn_fs),
    .oe    (oe_fs),
    .busy  (busy_fs)
  );

  usb_tx_serializer #(.LOW_SPEED(1'b1)) dut_ls (
    .clk   (clk),
    .rst   (rst),
    .clken (clken),
    .tx    (if_ls.slave),
    .dp    (dp_ls),
    .dn    (dn_ls),
    .oe    (oe_ls),
    .busy  (busy_ls)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  logic rdy_fs, rdy_ls;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] sym(input logic dpv, input logic dnv, input bit ls);
    if (!dpv && !dnv) return "0";
    else if (dpv == ~ls) return "J";
    else return "K";
  endfunction

  // One bit time: three clocks with clken low, then one with clken high.
  // tx_ready is captured inside the clken cycle; outputs are valid on return.
  task automatic step();
    clken = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clken = 1'b1;
    #1;
    rdy_fs = if_fs.tx_ready;
    rdy_ls = if_ls.tx_ready;
    @(posedge clk);
    #1;
    clken = 1'b0;
  endtask

  task automatic set_in(input bit ls, input logic v, input logic [7:0] d);
    if (ls) begin
      if_ls.tx_valid = v;
      if_ls.tx_data  = d;
    end else begin
      if_fs.tx_valid = v;
      if_fs.tx_data  = d;
    end
  endtask

  task automatic run_pkt(input bit ls, input string name, input string exp,
                         input logic [7:0] b0, input logic [7:0] b1, input int nb,
                         input int rdy1, input int rdy2);
    int   nrdy;
    logic dpv, dnv, oev, busyv, rdyv;
    nrdy = 0;
    set_in(ls, 1'b1, b0);
    for (int i = 1; i <= exp.len(); i++) begin
      step();
      dpv   = ls ? dp_ls   : dp_fs;
      dnv   = ls ? dn_ls   : dn_fs;
      oev   = ls ? oe_ls   : oe_fs;
      busyv = ls ? busy_ls : busy_fs;
      rdyv  = ls ? rdy_ls  : rdy_fs;
      if (rdyv) begin
        nrdy++;
        check($sformatf("%s ready_pos%0d", name, nrdy), 32'(i), 32'((nrdy == 1) ? rdy1 : rdy2));
        if (nrdy >= nb) set_in(ls, 1'b0, 8'h00);
        else            set_in(ls, 1'b1, b1);
      end
      check($sformatf("%s line_bit%0d", name, i), 32'(sym(dpv, dnv, ls)), 32'(exp[i-1]));
      check($sformatf("%s oe_bit%0d", name, i), 32'(oev), 32'd1);
      check($sformatf("%s busy_bit%0d", name, i), 32'(busyv), 32'd1);
    end
    check($sformatf("%s ready_count", name), 32'(nrdy), 32'(nb));
    set_in(ls, 1'b0, 8'h00);
    step();
    dpv = ls ? dp_ls : dp_fs;
    dnv = ls ? dn_ls : dn_fs;
    check($sformatf("%s idle_line", name), 32'(sym(dpv, dnv, ls)), 32'("J"));
    check($sformatf("%s idle_oe", name), 32'(ls ? oe_ls : oe_fs), 32'd0);
    check($sformatf("%s idle_busy", name), 32'(ls ? busy_ls : busy_fs), 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    clken = 1'b0;
    set_in(1'b0, 1'b1, 8'hA5);
    set_in(1'b1, 1'b0, 8'h00);

    // Reset with clken and tx_valid high: ready must stay low, line J.
    repeat (2) @(posedge clk);
    @(negedge clk);
    clken = 1'b1;
    #1;
    check("rst tx_ready", 32'(if_fs.tx_ready), 32'd0);
    @(posedge clk);
    #1;
    clken = 1'b0;
    check("rst dp_fs", 32'(dp_fs), 32'd1);
    check("rst dn_fs", 32'(dn_fs), 32'd0);
    check("rst oe_fs", 32'(oe_fs), 32'd0);
    check("rst busy_fs", 32'(busy_fs), 32'd0);
    check("rst dp_ls", 32'(dp_ls), 32'd0);
    check("rst dn_ls", 32'(dn_ls), 32'd1);

    @(negedge clk);
    rst = 1'b0;
    set_in(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("idle line%0d", i), 32'(sym(dp_fs, dn_fs, 1'b0)), 32'("J"));
      check($sformatf("idle oe%0d", i), 32'(oe_fs), 32'd0);
      check($sformatf("idle busy%0d", i), 32'(busy_fs), 32'd0);
      check($sformatf("idle ready%0d", i), 32'(rdy_fs), 32'd0);
    end

    run_pkt(1'b0, "a5", "KJKJKJKKKJJKJJKK00J", 8'hA5, 8'h00, 1, 9, 0);
    run_pkt(1'b0, "ff", "KJKJKJKKKKKKKJJJJ00J", 8'hFF, 8'h00, 1, 9, 0);
    run_pkt(1'b0, "ff_3f", "KJKJKJKKKKKKKJJJJJJJKKKKJK00J", 8'hFF, 8'h3F, 2, 9, 18);
    run_pkt(1'b0, "fc_00", "KJKJKJKKJKKKKKKKJKJKJKJKJ00J", 8'hFC, 8'h00, 2, 9, 18);
    run_pkt(1'b1, "ls_00", "KJKJKJKKJKJKJKJK00J", 8'h00, 8'h00, 1, 9, 0);

    // Reset in the middle of a data byte.
    set_in(1'b0, 1'b1, 8'hFF);
    repeat (11) step();
    check("mid oe_before", 32'(oe_fs), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst oe", 32'(oe_fs), 32'd0);
    check("mid_rst line", 32'(sym(dp_fs, dn_fs, 1'b0)), 32'("J"));
    check("mid_rst busy", 32'(busy_fs), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    set_in(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post_rst line%0d", i), 32'(sym(dp_fs, dn_fs, 1'b0)), 32'("J"));
      check($sformatf("post_rst oe%0d", i), 32'(oe_fs), 32'd0);
    end
    run_pkt(1'b0, "a5_again", "KJKJKJKKKJJKJJKK00J", 8'hA5, 8'h00, 1, 9, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
